// File: rtl/int_controller_if.sv
// Core-side bundle of the interrupt controller: source lines,
// config register port and the request/ack/reti handshake.
interface int_controller_if #(
    parameter int N_SRC = 8
);
    logic [N_SRC-1:0] irq_i;
    logic             cfg_we_i;
    logic [2:0]       cfg_addr_i;
    logic [7:0]       cfg_dat_i;
    logic [7:0]       cfg_dat_o;
    logic             int_req_o;
    logic             int_ack_i;
    logic             reti_i;
    logic [7:0]       int_vec_o;
    logic             in_service_o;

    modport slave (
        input  irq_i, cfg_we_i, cfg_addr_i, cfg_dat_i,
        input  int_ack_i, reti_i,
        output cfg_dat_o, int_req_o, int_vec_o, in_service_o
    );

    modport master (
        output irq_i, cfg_we_i, cfg_addr_i, cfg_dat_i,
        output int_ack_i, reti_i,
        input  cfg_dat_o, int_req_o, int_vec_o, in_service_o
    );
endinterface

// File: rtl/int_controller.sv
// Prioritised maskable interrupt controller for the Gumnut core.
// Edge/level sources, one request at a time, vector = VECBASE + id.
module int_controller #(
    parameter int N_SRC = 8
) (
    input logic            clk,
    input logic            rst,
    input logic            cen,
    int_controller_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SVC} state_t;

    state_t           r_state;
    logic [2:0]       r_id;
    logic             r_req;
    logic             r_svc;
    logic             r_gie;
    logic [N_SRC-1:0] r_prev;
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] r_edge;
    logic [N_SRC-1:0] r_pend;
    logic [7:0]       r_vbase;

    logic [7:0]       w_mask8;
    logic [7:0]       w_edge8;
    logic [7:0]       w_pend8;
    logic [7:0]       w_act8;
    logic [7:0]       w_ackhot;
    logic [7:0]       w_rdat;
    logic [2:0]       w_sel;
    logic             w_any;
    logic             w_ack;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_set;
    logic [N_SRC-1:0] w_ackclr;
    logic [N_SRC-1:0] w_pend_nxt;

    assign w_mask8 = 8'(r_mask);
    assign w_edge8 = 8'(r_edge);
    assign w_pend8 = 8'(r_pend);
    assign w_act8  = r_gie ? (w_pend8 & w_mask8) : 8'h00;
    assign w_any   = |w_act8;

    always_comb begin
        w_sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_act8[i]) w_sel = 3'(i);
        end
    end

    // Edge bits: new rising edge beats both software and ack clears
    assign w_ack    = (r_state == S_REQ) && bus.int_ack_i;
    assign w_ackhot = (w_ack && w_edge8[r_id]) ? (8'h01 << r_id) : 8'h00;
    assign w_ackclr = w_ackhot[N_SRC-1:0];
    assign w_clr    = (bus.cfg_we_i && bus.cfg_addr_i == 3'd3)
                    ? bus.cfg_dat_i[N_SRC-1:0] : '0;
    assign w_set    = bus.irq_i & ~r_prev;
    assign w_pend_nxt = (r_edge & (w_set | (r_pend & ~(w_clr | w_ackclr))))
                      | (~r_edge & bus.irq_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev  <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_edge  <= '0;
            r_gie   <= 1'b0;
            r_vbase <= 8'h00;
        end else if (cen) begin
            r_prev <= bus.irq_i;
            r_pend <= w_pend_nxt;
            if (bus.cfg_we_i) begin
                unique case (bus.cfg_addr_i)
                    3'd0:    r_gie   <= bus.cfg_dat_i[0];
                    3'd1:    r_mask  <= bus.cfg_dat_i[N_SRC-1:0];
                    3'd2:    r_edge  <= bus.cfg_dat_i[N_SRC-1:0];
                    3'd4:    r_vbase <= bus.cfg_dat_i;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_id    <= 3'd0;
            r_req   <= 1'b0;
            r_svc   <= 1'b0;
        end else if (cen) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id    <= w_sel;
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus.int_ack_i) begin
                        r_state <= S_SVC;
                        r_req   <= 1'b0;
                        r_svc   <= 1'b1;
                    end else if (!w_act8[r_id]) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                S_SVC: begin
                    if (bus.reti_i) begin
                        r_state <= S_IDLE;
                        r_svc   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_svc   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_rdat = 8'h00;
        unique case (bus.cfg_addr_i)
            3'd0:    w_rdat = {7'd0, r_gie};
            3'd1:    w_rdat = w_mask8;
            3'd2:    w_rdat = w_edge8;
            3'd3:    w_rdat = w_pend8;
            3'd4:    w_rdat = r_vbase;
            default: w_rdat = 8'h00;
        endcase
    end

    assign bus.cfg_dat_o    = w_rdat;
    assign bus.int_req_o    = r_req;
    assign bus.in_service_o = r_svc;
    assign bus.int_vec_o    = r_vbase + {5'd0, r_id};
endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed vector table, corner sequences,
// and randomized traffic against a behavioural reference model.
module tb_int_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cen = 1'b1;

    int_controller_if #(.N_SRC(8)) bus ();

    int_controller #(.N_SRC(8)) dut (
        .clk(clk),
        .rst(rst),
        .cen(cen),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [7:0] irq;
        logic       we;
        logic [2:0] addr;
        logic [7:0] dat;
        logic       ack;
        logic       reti;
        logic       req;
        logic       svc;
        logic [7:0] vec;
        logic [7:0] rdat;
    } vec_t;

    vec_t tbl[20];

    // Reference model state
    bit [7:0] m_pend, m_mask, m_edge, m_vbase, m_prev;
    bit       m_gie, m_req, m_svc;
    int       m_id;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.irq_i      = 8'h00;
        bus.cfg_we_i   = 1'b0;
        bus.cfg_addr_i = 3'd0;
        bus.cfg_dat_i  = 8'h00;
        bus.int_ack_i  = 1'b0;
        bus.reti_i     = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.cfg_we_i   = 1'b1;
        bus.cfg_addr_i = a;
        bus.cfg_dat_i  = d;
        tick();
        bus.cfg_we_i   = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp,
                      input string name);
        bus.cfg_addr_i = a;
        #1;
        chk(name, bus.cfg_dat_o, exp);
    endtask

    function automatic vec_t mk(
        input logic [7:0] irq, input logic we, input logic [2:0] a,
        input logic [7:0] d, input logic ack, input logic reti,
        input logic req, input logic svc, input logic [7:0] vec,
        input logic [7:0] rdat);
        vec_t v;
        v.irq = irq; v.we = we; v.addr = a; v.dat = d;
        v.ack = ack; v.reti = reti; v.req = req; v.svc = svc;
        v.vec = vec; v.rdat = rdat;
        return v;
    endfunction

    task automatic m_reset();
        m_pend = 0; m_mask = 0; m_edge = 0; m_vbase = 0; m_prev = 0;
        m_gie = 0; m_req = 0; m_svc = 0; m_id = 0;
    endtask

    function automatic bit [7:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {7'd0, m_gie};
            3'd1: return m_mask;
            3'd2: return m_edge;
            3'd3: return m_pend;
            3'd4: return m_vbase;
            default: return 8'h00;
        endcase
    endfunction

    // One enabled clock of the controller, from the rules in plain terms
    task automatic m_step(input logic [7:0] irq, input logic we,
                          input logic [2:0] a, input logic [7:0] d,
                          input logic ack, input logic reti,
                          input logic en);
        bit [7:0] act;
        bit [7:0] np;
        bit       p;
        if (!en) return;
        act = m_gie ? (m_pend & m_mask) : 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (m_edge[i]) begin
                p = m_pend[i];
                if (we && a == 3'd3 && d[i]) p = 1'b0;
                if (m_req && ack && m_id == i) p = 1'b0;
                if (irq[i] && !m_prev[i]) p = 1'b1;
                np[i] = p;
            end else begin
                np[i] = irq[i];
            end
        end
        if (m_req) begin
            if (ack) begin
                m_req = 0;
                m_svc = 1;
            end else if (!act[m_id]) begin
                m_req = 0;
            end
        end else if (m_svc) begin
            if (reti) m_svc = 0;
        end else if (act != 0) begin
            for (int i = 7; i >= 0; i--) if (act[i]) m_id = i;
            m_req = 1;
        end
        if (we) begin
            case (a)
                3'd0: m_gie = d[0];
                3'd1: m_mask = d;
                3'd2: m_edge = d;
                3'd4: m_vbase = d;
                default: ;
            endcase
        end
        m_pend = np;
        m_prev = irq;
    endtask

    initial begin
        bit [7:0] r_irq;
        logic [7:0] exp_vec;

        clr_in();
        rst = 1'b0;
        #1;
        chk("rst_req", bus.int_req_o, 1'b0);
        chk("rst_svc", bus.in_service_o, 1'b0);
        chk("rst_vec", bus.int_vec_o, 8'h00);
        for (int a = 0; a < 8; a++)
            rd(3'(a), 8'h00, $sformatf("rst_reg%0d", a));
        tick();
        tick();
        rst = 1'b1;
        tick();

        // irq, we, addr, dat, ack, reti -> req, svc, vec, rdat
        tbl[0]  = mk(8'h00, 1, 3'd2, 8'h01, 0, 0, 0, 0, 8'h00, 8'h01);
        tbl[1]  = mk(8'h00, 1, 3'd1, 8'h01, 0, 0, 0, 0, 8'h00, 8'h01);
        tbl[2]  = mk(8'h00, 1, 3'd4, 8'h40, 0, 0, 0, 0, 8'h40, 8'h40);
        tbl[3]  = mk(8'h00, 1, 3'd0, 8'h01, 0, 0, 0, 0, 8'h40, 8'h01);
        tbl[4]  = mk(8'h01, 0, 3'd3, 8'h00, 0, 0, 0, 0, 8'h40, 8'h01);
        tbl[5]  = mk(8'h00, 0, 3'd3, 8'h00, 0, 0, 1, 0, 8'h40, 8'h01);
        tbl[6]  = mk(8'h00, 0, 3'd3, 8'h00, 1, 0, 0, 1, 8'h40, 8'h00);
        tbl[7]  = mk(8'h00, 0, 3'd3, 8'h00, 0, 0, 0, 1, 8'h40, 8'h00);
        tbl[8]  = mk(8'h00, 0, 3'd3, 8'h00, 0, 1, 0, 0, 8'h40, 8'h00);
        tbl[9]  = mk(8'h00, 0, 3'd3, 8'h00, 0, 0, 0, 0, 8'h40, 8'h00);
        tbl[10] = mk(8'h00, 1, 3'd2, 8'h25, 0, 0, 0, 0, 8'h40, 8'h25);
        tbl[11] = mk(8'h00, 1, 3'd1, 8'h25, 0, 0, 0, 0, 8'h40, 8'h25);
        tbl[12] = mk(8'h24, 0, 3'd3, 8'h00, 0, 0, 0, 0, 8'h40, 8'h24);
        tbl[13] = mk(8'h24, 0, 3'd3, 8'h00, 0, 0, 1, 0, 8'h42, 8'h24);
        tbl[14] = mk(8'h00, 0, 3'd3, 8'h00, 1, 0, 0, 1, 8'h42, 8'h20);
        tbl[15] = mk(8'h00, 0, 3'd3, 8'h00, 0, 1, 0, 0, 8'h42, 8'h20);
        tbl[16] = mk(8'h00, 0, 3'd3, 8'h00, 0, 0, 1, 0, 8'h45, 8'h20);
        tbl[17] = mk(8'h00, 0, 3'd3, 8'h00, 1, 0, 0, 1, 8'h45, 8'h00);
        tbl[18] = mk(8'h00, 0, 3'd3, 8'h00, 0, 1, 0, 0, 8'h45, 8'h00);
        tbl[19] = mk(8'h00, 0, 3'd3, 8'h00, 0, 0, 0, 0, 8'h45, 8'h00);

        foreach (tbl[i]) begin
            bus.irq_i      = tbl[i].irq;
            bus.cfg_we_i   = tbl[i].we;
            bus.cfg_addr_i = tbl[i].addr;
            bus.cfg_dat_i  = tbl[i].dat;
            bus.int_ack_i  = tbl[i].ack;
            bus.reti_i     = tbl[i].reti;
            tick();
            chk($sformatf("row%0d", i),
                {bus.int_req_o, bus.in_service_o, bus.int_vec_o,
                 bus.cfg_dat_o},
                {tbl[i].req, tbl[i].svc, tbl[i].vec, tbl[i].rdat});
        end
        clr_in();

        // Mask removal withdraws a latched request, pending survives
        wr(3'd2, 8'h2D);
        wr(3'd1, 8'h2D);
        bus.irq_i = 8'h08;
        tick();
        bus.irq_i = 8'h00;
        tick();
        chk("src3_req", {bus.int_req_o, bus.int_vec_o}, {1'b1, 8'h43});
        wr(3'd1, 8'h25);
        chk("withdraw_w", bus.int_req_o, 1'b1);
        tick();
        chk("withdraw_w1", bus.int_req_o, 1'b0);
        rd(3'd3, 8'h08, "pend3_kept");
        wr(3'd1, 8'h2D);
        chk("reen_w", bus.int_req_o, 1'b0);
        tick();
        chk("reen_req", {bus.int_req_o, bus.int_vec_o}, {1'b1, 8'h43});
        bus.int_ack_i = 1'b1;
        tick();
        bus.int_ack_i = 1'b0;
        chk("src3_svc", bus.in_service_o, 1'b1);
        bus.reti_i = 1'b1;
        tick();
        bus.reti_i = 1'b0;
        chk("src3_done", {bus.int_req_o, bus.in_service_o}, 2'b00);

        // Level source held through reti is re-requested
        wr(3'd2, 8'h00);
        wr(3'd1, 8'h02);
        bus.irq_i = 8'h02;
        tick();
        tick();
        chk("lvl_req", {bus.int_req_o, bus.int_vec_o}, {1'b1, 8'h41});
        bus.int_ack_i = 1'b1;
        tick();
        bus.int_ack_i = 1'b0;
        chk("lvl_svc", bus.in_service_o, 1'b1);
        wr(3'd3, 8'h02);
        rd(3'd3, 8'h02, "lvl_pend_wr");
        bus.reti_i = 1'b1;
        tick();
        bus.reti_i = 1'b0;
        chk("lvl_idle_r", {bus.int_req_o, bus.in_service_o}, 2'b00);
        tick();
        chk("lvl_rereq", bus.int_req_o, 1'b1);
        bus.int_ack_i = 1'b1;
        tick();
        bus.int_ack_i = 1'b0;
        bus.irq_i = 8'h00;
        tick();
        bus.reti_i = 1'b1;
        tick();
        bus.reti_i = 1'b0;
        tick();
        tick();
        chk("lvl_quiet", {bus.int_req_o, bus.in_service_o}, 2'b00);

        // Vector wrap, then async reset in the middle of service
        wr(3'd2, 8'h80);
        wr(3'd1, 8'h80);
        wr(3'd4, 8'hFE);
        bus.irq_i = 8'h80;
        tick();
        bus.irq_i = 8'h00;
        tick();
        chk("wrap_vec", {bus.int_req_o, bus.int_vec_o}, {1'b1, 8'h05});
        bus.int_ack_i = 1'b1;
        tick();
        bus.int_ack_i = 1'b0;
        chk("wrap_svc", bus.in_service_o, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_svc", {bus.int_req_o, bus.in_service_o}, 2'b00);
        chk("arst_vec", bus.int_vec_o, 8'h00);
        for (int a = 0; a < 5; a++)
            rd(3'(a), 8'h00, $sformatf("arst_reg%0d", a));
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Clock enable freeze and out-of-state handshakes
        wr(3'd2, 8'h01);
        wr(3'd1, 8'h01);
        wr(3'd0, 8'h01);
        wr(3'd4, 8'h10);
        wr(3'd5, 8'hFF);
        rd(3'd5, 8'h00, "addr5_zero");
        cen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.irq_i = (i == 2) ? 8'h01 : 8'h00;
            tick();
        end
        bus.irq_i = 8'h00;
        rd(3'd3, 8'h00, "cen_pend");
        cen = 1'b1;
        tick();
        tick();
        chk("cen_noreq", bus.int_req_o, 1'b0);
        bus.int_ack_i = 1'b1;
        bus.reti_i = 1'b1;
        tick();
        bus.int_ack_i = 1'b0;
        bus.reti_i = 1'b0;
        chk("idle_hs_ign", {bus.int_req_o, bus.in_service_o}, 2'b00);
        bus.irq_i = 8'h01;
        tick();
        bus.irq_i = 8'h00;
        tick();
        chk("cen_req", {bus.int_req_o, bus.int_vec_o}, {1'b1, 8'h10});
        bus.reti_i = 1'b1;
        tick();
        bus.reti_i = 1'b0;
        chk("req_reti_ign", bus.int_req_o, 1'b1);
        cen = 1'b0;
        bus.int_ack_i = 1'b1;
        tick();
        tick();
        cen = 1'b1;
        bus.int_ack_i = 1'b0;
        chk("cen_hold", {bus.int_req_o, bus.in_service_o}, 2'b10);
        bus.int_ack_i = 1'b1;
        tick();
        chk("ack_svc", bus.in_service_o, 1'b1);
        tick();
        bus.int_ack_i = 1'b0;
        chk("svc_ack_ign", {bus.int_req_o, bus.in_service_o}, 2'b01);
        bus.reti_i = 1'b1;
        tick();
        clr_in();

        // Randomized traffic against the reference model
        rst = 1'b0;
        #2;
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        r_irq = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(7) == 0) r_irq[b] = ~r_irq[b];
            bus.irq_i      = r_irq;
            bus.cfg_we_i   = ($urandom_range(9) == 0);
            bus.cfg_addr_i = 3'($urandom_range(7));
            bus.cfg_dat_i  = 8'($urandom);
            if (c < 4) begin
                bus.cfg_we_i   = 1'b1;
                bus.cfg_addr_i = (c == 3) ? 3'd4 : 3'(c);
                if (c == 0) bus.cfg_dat_i = 8'h01;
                if (c == 1) bus.cfg_dat_i = 8'hFF;
            end
            bus.int_ack_i = m_req ? ($urandom_range(2) == 0)
                                  : ($urandom_range(9) == 0);
            bus.reti_i    = m_svc ? ($urandom_range(3) == 0)
                                  : ($urandom_range(9) == 0);
            cen = ($urandom_range(9) != 0);
            @(posedge clk);
            m_step(bus.irq_i, bus.cfg_we_i, bus.cfg_addr_i, bus.cfg_dat_i,
                   bus.int_ack_i, bus.reti_i, cen);
            #1;
            exp_vec = 8'(m_vbase + 8'(m_id));
            chk($sformatf("rand%0d", c),
                {bus.int_req_o, bus.in_service_o, bus.int_vec_o,
                 bus.cfg_dat_o},
                {m_req, m_svc, exp_vec, m_read(bus.cfg_addr_i)});
        end
        clr_in();
        cen = 1'b1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
